// File: rtl/auto_scale_ctrl.sv
// Automatic gain-shift controller for a 32->16 bit requantiser: tracks windowed peak |din|
// and derives the largest safe left shift (fast attack, slow release, manual override).
module auto_scale_ctrl #(
  parameter int WIN_LOG2  = 4,
  parameter int HEADROOM  = 1,
  parameter int SHIFT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        enable,
  input  logic [15:0] manual_coeff,
  output logic [15:0] scaled_coeff,
  output logic        coeff_update,
  output logic [31:0] peak_out,
  output logic        win_done
);

  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  logic [WIN_LOG2-1:0] cnt;
  logic [31:0]         peak;
  logic [31:0]         peak_lat;
  logic [31:0]         mag;
  logic [31:0]         peak_next;
  logic                c1_valid;
  logic                c2_valid;
  logic                first_win;
  logic [7:0]          target;
  logic [7:0]          target_next;
  logic [5:0]          lz;
  logic signed [7:0]   shift_raw;

  function automatic logic [5:0] count_lz(input logic [31:0] v);
    count_lz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) count_lz = 6'(31 - i);
    end
  endfunction

  // -2**31 has no positive twin, so it saturates to the largest positive magnitude
  always_comb begin
    mag = din;
    if (din[31]) mag = (din == 32'h8000_0000) ? 32'h7FFF_FFFF : (~din + 32'd1);
  end

  always_comb peak_next = (mag > peak) ? mag : peak;

  always_comb begin
    lz        = count_lz(peak_lat);
    shift_raw = $signed({2'b00, lz}) - 8'sd1 - 8'(HEADROOM);
    if (shift_raw < 8'sd0)
      target_next = 8'd0;
    else if (shift_raw > $signed(8'(SHIFT_MAX)))
      target_next = 8'(SHIFT_MAX);
    else
      target_next = 8'(shift_raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      peak         <= '0;
      peak_lat     <= '0;
      c1_valid     <= 1'b0;
      c2_valid     <= 1'b0;
      first_win    <= 1'b1;
      target       <= '0;
      scaled_coeff <= '0;
      coeff_update <= 1'b0;
      peak_out     <= '0;
      win_done     <= 1'b0;
    end else if (!enable) begin
      // Manual mode: measurement idle, pipeline flushed, next auto update loads directly
      cnt          <= '0;
      peak         <= '0;
      c1_valid     <= 1'b0;
      c2_valid     <= 1'b0;
      first_win    <= 1'b1;
      scaled_coeff <= manual_coeff;
      coeff_update <= 1'b0;
      win_done     <= 1'b0;
    end else begin
      c1_valid     <= 1'b0;
      c2_valid     <= 1'b0;
      coeff_update <= 1'b0;
      win_done     <= 1'b0;

      if (din_valid) begin
        if (cnt == CNT_LAST) begin
          peak_lat <= peak_next;
          peak     <= '0;
          cnt      <= '0;
          c1_valid <= 1'b1;
        end else begin
          peak <= peak_next;
          cnt  <= cnt + 1'b1;
        end
      end

      if (c1_valid) begin
        win_done <= 1'b1;
        peak_out <= peak_lat;
        target   <= target_next;
        c2_valid <= 1'b1;
      end

      if (c2_valid) begin
        coeff_update <= 1'b1;
        first_win    <= 1'b0;
        if (first_win)
          scaled_coeff <= {8'd0, target};
        else if ({8'd0, target} < scaled_coeff)
          scaled_coeff <= {8'd0, target};
        else if ({8'd0, target} > scaled_coeff)
          scaled_coeff <= scaled_coeff + 16'd1;
      end
    end
  end

endmodule
